mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store front end between the core and Common_Memory (word-wide, word-indexed, negedge write, comb read).
//  Accepts byte/half/word load-store requests via valid/ready; performs read-modify-write for sub-word stores,
//  sign/zero extension for loads, range checking; returns one response per request via valid/ready.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte address of memory word 0
//  ADDR_SPAN   256            mapped size in bytes (multiple of 4); byte addr valid iff BASE<=a<BASE+SPAN
// PORTS
//  clk           in   1   system clock, rising-edge logic
//  rst           in   1   asynchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   unit can accept (high only in IDLE)
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word; 11 treated as word
//  req_unsigned  in   1   loads: 1=zero-extend, 0=sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid     out  1   response present
//  rsp_ready     in   1   consumer accepts response
//  rsp_rdata     out  32  load result, extended; 0 for stores and errors
//  rsp_err       out  1   out-of-range (or misaligned, see CONFIGURATION)
//  mem_adr       out  32  word index to memory = (addr-BASE_ADDR)>>2
//  mem_wd        out  32  merged write word
//  mem_wr        out  1   memory write strobe
//  mem_oe        out  1   memory read enable
//  mem_rd        in   32  memory read data (combinational from mem_adr)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wr=0, mem_oe=0, mem_adr=0, mem_wd=0.
//  States IDLE, RD, WR, RSP; mem_* decoded from registered state/captures (no comb path from req_* inputs).
//  IDLE: on req_valid&req_ready capture addr/size/we/wdata/unsigned. Error -> RSP (no memory access);
//    load or sub-word store -> RD; word store -> WR.
//  RD (1 cycle): mem_oe=1; mem_rd captured at next posedge. Load -> RSP with extracted data; store -> WR.
//  WR (1 cycle): mem_wr=1 exactly one cycle, mem_wd = old word with selected lane(s) replaced
//    (byte lane addr[1:0], half lane addr[1]); word store writes req_wdata verbatim. -> RSP.
//  RSP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on rsp_valid&rsp_ready -> IDLE.
//    No new request accepted in the same cycle as the response handshake.
//  Latency accept(T)->rsp_valid: load T+2, word store T+2, sub-word store T+3, error T+1.
//  Little-endian lanes: byte at addr[1:0]=n is bits [8n+7:8n]; half at addr[1]=h is bits [16h+15:16h].
//  Range: addr outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN) -> rsp_err=1, rsp_rdata=0, mem_wr/mem_oe never set.
//    Last valid word at BASE+SPAN-4 is accepted normally; subtraction is modulo 2^32, no wrap into range.
//  mem_wr/mem_oe are 0 in every state other than WR/RD; mem_adr holds last value otherwise.
//  rst mid-operation: asynchronous return to IDLE; mem_wr drops immediately; pending write/response discarded.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 -> error response
//    (rsp_err=1, T+1, no memory access).
//  Not defined: low address bits forced to size alignment (half clears addr[0], word clears addr[1:0]);
//    no error for misalignment; range check uses the aligned address.
// TESTING
//  1 Word store 0xDEADBEEF @0x10 -> mem_wr high 1 cycle, mem_adr=4, mem_wd=0xDEADBEEF; load word @0x10 -> 0xDEADBEEF at T+2.
//  2 Byte store 0xAB @0x13 -> RD then WR, word=0xABADBEEF; byte load @0x13 signed -> 0xFFFFFFAB, unsigned -> 0x000000AB.
//  3 Half load @0x12 signed -> 0xFFFFABAD; half store 0x1234 @0x10 then word load -> 0xABAD1234.
//  4 Load @0x100 (BASE=0,SPAN=256) -> rsp_err=1, rsp_rdata=0 at T+1, mem_oe/mem_wr never high; @0xFC accepted.
//  5 rsp_ready low 5 cycles -> rsp_valid, rsp_rdata stable, req_ready=0; req_valid ignored until handshake.
//  6 rst asserted during WR -> mem_wr=0 immediately, IDLE; word load @0x11 -> err=1 with macro, else reads word 4.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end with sub-word RMW, extension and range check
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests return an error instead of being aligned.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_SPAN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  output logic        mem_wr,
  output logic        mem_oe,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

  localparam logic [31:0] SPAN = 32'(ADDR_SPAN);

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_adr_q, mem_adr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] aligned_addr, chk_addr, offset;
  logic        misalign, req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data, merged, lane_mask, lane_data;

  always_comb begin
    case (req_size)
      2'b00:   aligned_addr = req_addr;
      2'b01:   aligned_addr = {req_addr[31:1], 1'b0};
      default: aligned_addr = {req_addr[31:2], 2'b00};
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_size == 2'b01) && req_addr[0]) || (req_size[1] && (req_addr[1:0] != 2'b00));
    chk_addr = req_addr;
`else
    misalign = 1'b0;
    chk_addr = aligned_addr;
`endif
    // Modulo subtraction: addresses below BASE wrap to huge offsets and fail the compare.
    offset  = chk_addr - BASE_ADDR;
    req_err = misalign || (offset >= SPAN);
  end

  always_comb begin
    byte_sel = 8'(mem_rd >> {lane_q, 3'b000});
    half_sel = 16'(mem_rd >> {lane_q[1], 4'b0000});
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = mem_rd;
    endcase
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00FF << {lane_q, 3'b000};
      lane_data = {24'h0, wdata_q[7:0]} << {lane_q, 3'b000};
    end else begin
      lane_mask = 32'h0000_FFFF << {lane_q[1], 4'b0000};
      lane_data = {16'h0, wdata_q} << {lane_q[1], 4'b0000};
    end
    merged = (mem_rd & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    size_d    = size_q;
    we_d      = we_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    mem_adr_d = mem_adr_q;
    mem_wd_d  = mem_wd_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lane_d  = aligned_addr[1:0];
          size_d  = req_size[1] ? 2'b10 : req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata[15:0];
          rdata_d = 32'h0;
          err_d   = req_err;
          if (req_err) begin
            state_d = S_RSP;
          end else begin
            mem_adr_d = offset >> 2;
            if (req_we && req_size[1]) begin
              mem_wd_d = req_wdata;
              state_d  = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          mem_wd_d = merged;
          state_d  = S_WR;
        end else begin
          rdata_d = load_data;
          state_d = S_RSP;
        end
      end
      S_WR:    state_d = S_RSP;
      default: if (rsp_ready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lane_q    <= 2'b00;
      size_q    <= 2'b00;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= 16'h0;
      mem_adr_q <= 32'h0;
      mem_wd_q  <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      wdata_q   <= wdata_d;
      mem_adr_q <= mem_adr_d;
      mem_wd_q  <= mem_wd_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wd    = mem_wd_q;
  assign mem_wr    = (state_q == S_WR);
  assign mem_oe    = (state_q == S_RD);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic        mem_wr;
  logic        mem_oe;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63] = '{default: 32'h0};

  int errors = 0;
  int checks = 0;

  int          t_lat, t_wrc, t_oec;
  logic [31:0] t_rd, t_wadr, t_wwd;
  logic        t_err;

  mem_access_unit #(.BASE_ADDR(32'h0), .ADDR_SPAN(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_wr(mem_wr), .mem_oe(mem_oe), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_adr[5:0]];
  always @(negedge clk) if (mem_wr) mem[mem_adr[5:0]] <= mem_wd;

  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL txn_ready: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    t_lat = 0; t_wrc = 0; t_oec = 0; t_wadr = 32'hx; t_wwd = 32'hx;
    for (int i = 1; i <= 8 && t_lat == 0; i++) begin
      @(negedge clk);
      if (mem_wr) begin t_wrc++; t_wadr = mem_adr; t_wwd = mem_wd; end
      if (mem_oe) t_oec++;
      if (rsp_valid) t_lat = i;
    end
    t_rd = rsp_rdata; t_err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_wr, mem_oe} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 10000", {req_ready, rsp_valid, rsp_err, mem_wr, mem_oe});
    end
    checks++;
    if ({rsp_rdata, mem_adr, mem_wd} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h want 0", rsp_rdata, mem_adr, mem_wd);
    end
    rst = 1'b0;
  endtask

  task automatic test_word;
    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++;
    if (t_lat !== 2 || t_wrc !== 1 || t_oec !== 0 || t_err !== 1'b0) begin
      errors++; $display("FAIL word_store_timing: got lat=%0d wr=%0d oe=%0d err=%b want 2 1 0 0", t_lat, t_wrc, t_oec, t_err);
    end
    checks++;
    if (t_wadr !== 32'd4 || t_wwd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_store_bus: got adr=%h wd=%h want 4 deadbeef", t_wadr, t_wwd);
    end
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++;
    if (t_lat !== 2 || t_rd !== 32'hDEADBEEF || t_oec !== 1 || t_wrc !== 0) begin
      errors++; $display("FAIL word_load: got lat=%0d rd=%h oe=%0d wr=%0d want 2 deadbeef 1 0", t_lat, t_rd, t_oec, t_wrc);
    end
  endtask

  task automatic test_byte;
    txn(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AB);
    checks++;
    if (t_lat !== 3 || t_oec !== 1 || t_wrc !== 1 || t_wwd !== 32'hABADBEEF || t_wadr !== 32'd4) begin
      errors++; $display("FAIL byte_store: got lat=%0d oe=%0d wr=%0d wd=%h adr=%h want 3 1 1 abadbeef 4", t_lat, t_oec, t_wrc, t_wwd, t_wadr);
    end
    txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    checks++;
    if (t_rd !== 32'hFFFFFFAB || t_lat !== 2) begin
      errors++; $display("FAIL byte_load_signed: got %h lat=%0d want ffffffab 2", t_rd, t_lat);
    end
    txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    checks++;
    if (t_rd !== 32'h000000AB) begin
      errors++; $display("FAIL byte_load_unsigned: got %h want 000000ab", t_rd);
    end
    txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    checks++;
    if (t_rd !== 32'h000000BE) begin
      errors++; $display("FAIL byte_load_lane1: got %h want 000000be", t_rd);
    end
  endtask

  task automatic test_half;
    txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    checks++;
    if (t_rd !== 32'hFFFFABAD) begin
      errors++; $display("FAIL half_load_signed: got %h want ffffabad", t_rd);
    end
    txn(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF1234);
    checks++;
    if (t_lat !== 3 || t_wwd !== 32'hABAD1234) begin
      errors++; $display("FAIL half_store: got lat=%0d wd=%h want 3 abad1234", t_lat, t_wwd);
    end
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++;
    if (t_rd !== 32'hABAD1234) begin
      errors++; $display("FAIL half_store_readback: got %h want abad1234", t_rd);
    end
  endtask

  task automatic test_range;
    txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    checks++;
    if (t_lat !== 1 || t_err !== 1'b1 || t_rd !== 32'h0 || t_oec !== 0 || t_wrc !== 0) begin
      errors++; $display("FAIL range_load_100: got lat=%0d err=%b rd=%h oe=%0d wr=%0d want 1 1 0 0 0", t_lat, t_err, t_rd, t_oec, t_wrc);
    end
    txn(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h55);
    checks++;
    if (t_lat !== 1 || t_err !== 1'b1 || t_oec !== 0 || t_wrc !== 0) begin
      errors++; $display("FAIL range_store_wrap: got lat=%0d err=%b oe=%0d wr=%0d want 1 1 0 0", t_lat, t_err, t_oec, t_wrc);
    end
    txn(1'b1, 2'b10, 1'b0, 32'hFC, 32'h0BADF00D);
    checks++;
    if (t_err !== 1'b0 || t_wrc !== 1 || t_wadr !== 32'd63) begin
      errors++; $display("FAIL range_store_fc: got err=%b wr=%0d adr=%h want 0 1 3f", t_err, t_wrc, t_wadr);
    end
    txn(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    checks++;
    if (t_err !== 1'b0 || t_rd !== 32'h0BADF00D || t_lat !== 2) begin
      errors++; $display("FAIL range_load_fc: got err=%b rd=%h lat=%0d want 0 0badf00d 2", t_err, t_rd, t_lat);
    end
  endtask

  task automatic test_backpressure;
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h55555555;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 8);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_rsp_timeout: got rsp_valid=%b want 1", rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hABAD1234 || req_ready !== 1'b0 || rsp_err !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b rd=%h rdy=%b err=%b want 1 abad1234 0 0", i, rsp_valid, rsp_rdata, req_ready, rsp_err);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got v=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++;
    if (t_rd !== 32'hABAD1234) begin
      errors++; $display("FAIL bp_store_ignored: got %h want abad1234", t_rd);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_wr !== 1'b1) begin
      errors++; $display("FAIL mid_in_wr: got mem_wr=%b want 1", mem_wr);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got wr=%b rdy=%b v=%b want 0 1 0", mem_wr, req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checks++;
    if (t_rd !== 32'h0 || t_err !== 1'b0) begin
      errors++; $display("FAIL mid_write_discarded: got rd=%h err=%b want 0 0", t_rd, t_err);
    end
    txn(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (t_err !== 1'b1 || t_lat !== 1 || t_rd !== 32'h0 || t_oec !== 0) begin
      errors++; $display("FAIL misalign_word: got err=%b lat=%0d rd=%h oe=%0d want 1 1 0 0", t_err, t_lat, t_rd, t_oec);
    end
`else
    checks++;
    if (t_err !== 1'b0 || t_lat !== 2 || t_rd !== 32'hABAD1234) begin
      errors++; $display("FAIL misalign_word: got err=%b lat=%0d rd=%h want 0 2 abad1234", t_err, t_lat, t_rd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_range();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
